// File: rtl/calc_pkg.sv
// Shared types and constants for the result-to-BCD conversion stage.
package calc_pkg;

  localparam int CALC_WIDTH = 8;
  localparam int CALC_NDIG  = 3;
  localparam int DIGIT_W    = 4;

  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic overf;
    logic empty;
  } flags_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: add 3 when the digit is 5 or more.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);

  // 4-bit wrap is harmless: a legal digit never exceeds 9, so the sum tops out at 12.
  assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? (i_digit + BCD_ADJ_ADD) : i_digit;

endmodule

// File: rtl/result_bcd_converter.sv
// Captures the add/sub result and converts it to BCD with a bit-serial double-dabble engine.
// Define SIGNED_MODE_EN to treat Rin as two's complement and report its sign.
module result_bcd_converter
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int NDIG  = CALC_NDIG
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             Start,
  input  logic [WIDTH-1:0] Rin,
  input  logic             OverF_in,
  input  logic             Empty_in,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Hundreds,
  output logic [3:0]       Tens,
  output logic [3:0]       Ones,
  output logic             Sign,
  output logic             OverFlag,
  output logic             ZeroFlag
);

  localparam int SCR_W = DIGIT_W * NDIG;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t r_state, w_state_nxt;
  logic   w_load, w_last;

  logic [NDIG-1:0][DIGIT_W-1:0] r_scr, w_adj, w_scr_nxt;
  logic [2:0][DIGIT_W-1:0]      r_dig;
  logic [WIDTH-1:0]             r_oper, w_mag;
  logic [CNT_W-1:0]             r_cnt;
  flags_t                       r_pend, r_flags;

`ifdef SIGNED_MODE_EN
  logic w_sign, r_sign_pend, r_sign;
  assign w_sign = Rin[WIDTH-1];
  // 0x80 negates to itself, which read unsigned is exactly 128.
  assign w_mag  = w_sign ? (~Rin + WIDTH'(1)) : Rin;
`else
  assign w_mag  = Rin;
`endif

  genvar g;
  generate
    for (g = 0; g < NDIG; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_scr[g]),
        .o_digit (w_adj[g])
      );
    end
  endgenerate

  // Adjusted scratch shifts left; operand MSB feeds the Ones LSB.
  assign w_scr_nxt = (w_adj << 1) | {{(SCR_W-1){1'b0}}, r_oper[WIDTH-1]};

  always_ff @(posedge CLK) begin
    if (CLR) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_last      = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    unique case (r_state)
      IDLE, DONE: begin
        Done = (r_state == DONE);
        if (Start) begin
          w_load      = 1'b1;
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_oper  <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_flags <= '0;
      r_dig   <= '0;
    end else if (w_load) begin
      r_oper       <= w_mag;
      r_scr        <= '0;
      r_cnt        <= CNT_W'(WIDTH);
      r_pend.overf <= OverF_in;
      r_pend.empty <= Empty_in;
    end else if (r_state == SHIFT) begin
      r_scr  <= w_scr_nxt;
      r_oper <= r_oper << 1;
      r_cnt  <= r_cnt - CNT_W'(1);
      if (w_last) begin
        r_dig   <= w_scr_nxt[2:0];
        r_flags <= r_pend;
      end
    end
  end

`ifdef SIGNED_MODE_EN
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sign_pend <= 1'b0;
      r_sign      <= 1'b0;
    end else if (w_load) begin
      r_sign_pend <= w_sign;
    end else if (w_last) begin
      r_sign      <= r_sign_pend;
    end
  end
  assign Sign = r_sign;
`else
  assign Sign = 1'b0;
`endif

  assign Hundreds = r_dig[2];
  assign Tens     = r_dig[1];
  assign Ones     = r_dig[0];
  assign OverFlag = r_flags.overf;
  assign ZeroFlag = r_flags.empty;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Directed bench for result_bcd_converter with a queue scoreboard checked on every Done pulse.
module tb_result_bcd_converter;

  logic       CLK = 1'b0;
  logic       CLR, Start, OverF_in, Empty_in;
  logic [7:0] Rin;
  logic       Busy, Done, Sign, OverFlag, ZeroFlag;
  logic [3:0] Hundreds, Tens, Ones;

  result_bcd_converter dut (
    .CLK(CLK), .CLR(CLR), .Start(Start), .Rin(Rin),
    .OverF_in(OverF_in), .Empty_in(Empty_in),
    .Busy(Busy), .Done(Done),
    .Hundreds(Hundreds), .Tens(Tens), .Ones(Ones),
    .Sign(Sign), .OverFlag(OverFlag), .ZeroFlag(ZeroFlag)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] h, t, o;
    logic       s, of, zf;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc_n = 0, busy_cnt = 0, done_cnt = 0, last_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] r, input logic of, input logic zf);
    exp_t e;
    int   v;
`ifdef SIGNED_MODE_EN
    v   = int'($signed(r));
    e.s = (v < 0);
    if (v < 0) v = -v;
`else
    v   = int'(r);
    e.s = 1'b0;
`endif
    e.h  = 4'(v / 100);
    e.t  = 4'((v / 10) % 10);
    e.o  = 4'(v % 10);
    e.of = of;
    e.zf = zf;
    return e;
  endfunction

  task automatic cyc();
    exp_t e;
    @(posedge CLK);
    @(negedge CLK);
    cyc_n++;
    if (Busy) busy_cnt++;
    if (Done) begin
      done_cnt++;
      last_done = cyc_n;
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("hundreds", Hundreds, e.h);
        chk("tens",     Tens,     e.t);
        chk("ones",     Ones,     e.o);
        chk("sign",     Sign,     e.s);
        chk("overflag", OverFlag, e.of);
        chk("zeroflag", ZeroFlag, e.zf);
      end
    end
  endtask

  task automatic start(input logic [7:0] r, input logic of, input logic zf);
    Rin = r; OverF_in = of; Empty_in = zf; Start = 1'b1;
    sb.push_back(model(r, of, zf));
    cyc();
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim, output int n);
    int d0;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < lim) begin
      cyc();
      n++;
    end
    if (done_cnt == d0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int n, d, first;
    CLR = 1'b1; Start = 1'b0; Rin = '0; OverF_in = 1'b0; Empty_in = 1'b0;
    repeat (2) cyc();
    CLR = 1'b0;
    chk("reset_outs", {Busy, Done, Hundreds, Tens, Ones, Sign, OverFlag, ZeroFlag}, 32'd0);

    // 255 -> 2,5,5 with latency and busy length
    busy_cnt = 0;
    start(8'hFF, 1'b0, 1'b0);
    wait_done("t1", 20, n);
    chk("t1_latency", n + 1, 32'd9);
    chk("t1_busy", busy_cnt, 32'd8);
    cyc();
    chk("t1_done_pulse", Done, 1'b0);

    busy_cnt = 0;
    start(8'h00, 1'b0, 1'b1);
    wait_done("t2", 20, n);
    chk("t2_busy", busy_cnt, 32'd8);

    start(8'h80, 1'b1, 1'b0); wait_done("t3a", 20, n);
    start(8'hF6, 1'b0, 1'b0); wait_done("t3b", 20, n);
    start(8'h7F, 1'b0, 1'b0); wait_done("t3c", 20, n);

    // second Start mid-conversion must be dropped, first operand must stick
    start(8'h2A, 1'b0, 1'b0);
    repeat (2) cyc();
    Rin = 8'h63; Start = 1'b1;
    cyc();
    Start = 1'b0; Rin = 8'h00;
    wait_done("t4", 20, n);
    d = done_cnt;
    repeat (12) cyc();
    chk("t4_single_done", done_cnt, d);
    chk("t4_hold", {Hundreds, Tens, Ones}, 32'h042);

    // abort on the 4th SHIFT cycle
    start(8'h99, 1'b1, 1'b1);
    repeat (3) cyc();
    CLR = 1'b1;
    cyc();
    CLR = 1'b0;
    sb.delete();
    chk("t5_abort_outs", {Busy, Done, Hundreds, Tens, Ones, Sign, OverFlag, ZeroFlag}, 32'd0);
    d = done_cnt;
    repeat (12) cyc();
    chk("t5_no_done", done_cnt, d);
    CLR = 1'b1; Start = 1'b1; Rin = 8'h55;
    cyc();
    CLR = 1'b0; Start = 1'b0;
    chk("clr_beats_start", Busy, 1'b0);
    cyc();
    chk("clr_beats_start_idle", Busy, 1'b0);
    start(8'h10, 1'b0, 1'b0);
    wait_done("t5", 20, n);

    // back-to-back with Start held high
    Rin = 8'h0C; OverF_in = 1'b0; Empty_in = 1'b0; Start = 1'b1;
    sb.push_back(model(8'h0C, 1'b0, 1'b0));
    wait_done("t6a", 20, n);
    first = last_done;
    Rin = 8'hC8;
    sb.push_back(model(8'hC8, 1'b0, 1'b0));
    wait_done("t6b", 20, n);
    Start = 1'b0;
    chk("t6_gap", last_done - first, 32'd9);
    repeat (12) cyc();
    chk("sb_empty", sb.size(), 32'd0);
    chk("final_hold", {Hundreds, Tens, Ones}, 32'h200);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
